// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the multi-cycle unsigned multiply unit (multu / maddu).
// The control unit and the testbench decode against the same constants.
package mult_sequencer_pkg;

    localparam int MULT_WIDTH = 32;

    localparam logic [5:0] OP_MADDU    = 6'd28;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// EX-stage issue / HI-LO result bundle between the pipeline and the multiply unit.
interface mult_sequencer_if
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             start;
    logic             acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             rd_hilo;
    logic             kill;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, acc, opa, opb, rd_hilo, kill,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, acc, opa, opb, rd_hilo, kill,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: one multiplier bit retired per step, product
// accumulates in the upper half and shifts right with the adder carry.
module mult_shift_add
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] prod
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    always_comb begin
        addend = mplier[0] ? mcand : '0;
        sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (load) begin
            mcand  <= opa;
            mplier <= opb;
            prod   <= '0;
        end else if (step) begin
            // carry lands in the MSB; the retired low bit drops off
            prod   <= {sum, prod[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multiply unit controller: IDLE/RUN/COMMIT sequencing, HI/LO commit with
// optional accumulate, and the pipeline stall for dependent HI/LO access.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    mult_sequencer_if.slave   bus
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t               state;
    state_t               nxt;
    logic [CW-1:0]        cnt;
    logic                 acc_q;
    logic                 load;
    logic                 step;
    logic                 commit;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   hilo_nxt;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    mult_shift_add #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .opa  (bus.opa),
        .opb  (bus.opb),
        .prod (prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt    = state;
        load   = 1'b0;
        step   = 1'b0;
        commit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.kill) begin
                    load = 1'b1;
                    nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (bus.kill)              nxt = ST_IDLE;
                else if (cnt == CNT_LAST)  nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                // a flush arriving with the commit wins: nothing is written
                commit = !bus.kill;
                nxt    = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            acc_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            acc_q <= bus.acc;
        end else if (step) begin
            cnt   <= cnt + 1'b1;
        end
    end

    always_comb hilo_nxt = acc_q ? ({hi_q, lo_q} + prod) : prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) {hi_q, lo_q} <= hilo_nxt;
        end
    end

    // busy drops in the done cycle, so a read of the fresh HI/LO never stalls
    assign bus.busy  = (state != ST_IDLE);
    assign bus.stall = bus.busy & (bus.start | bus.rd_hilo);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
